// File: rtl/pmem_line_responder_if.sv
// pmem_line_responder_if: 128-bit physical-memory line bus between a cache (master) and memory (slave).
interface pmem_line_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_error;
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_error
  );
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_error
  );
endinterface

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency 128-bit line memory with a one-cycle completion pulse.
// Define PMEM_PROTOCOL_CHECK_EN to compile in the sticky protocol checker driving pmem_error.
module pmem_line_responder #(
  parameter int lines    = 32,
  parameter int log_line = 5,
  parameter int latency  = 4
) (
  input logic clk,
  input logic reset,
  pmem_line_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic is_wr;
  logic [log_line-1:0] idx;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic [127:0] mem [lines];
  logic accept, commit, sel_wr;
  logic [log_line-1:0] sel_idx;
  logic [127:0] sel_data;
  assign accept = state == IDLE && (bus.pmem_read || bus.pmem_write);
  always_comb begin
    state_n = state;
    state_n = state == RESP ? IDLE
            : state == BUSY ? (cnt == 8'd1 ? RESP : BUSY)
            : accept ? (latency == 1 ? RESP : BUSY) : IDLE;
  end
  // With latency 1 the commit edge is also the accept edge, so use the live inputs then.
  assign sel_wr   = state == IDLE ? bus.pmem_write : is_wr;
  assign sel_idx  = state == IDLE ? bus.pmem_address[log_line+3:4] : idx;
  assign sel_data = state == IDLE ? bus.pmem_wdata : wdata;
  assign commit   = state_n == RESP;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
      idx   <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        is_wr <= bus.pmem_write;
        idx   <= bus.pmem_address[log_line+3:4];
        wdata <= bus.pmem_wdata;
        cnt   <= 8'(latency - 1);
      end else if (state == BUSY) cnt <= cnt - 8'd1;
      if (commit && !sel_wr) rdata <= mem[sel_idx];
    end
  end
  always_ff @(posedge clk)
    if (commit && sel_wr && !reset) mem[sel_idx] <= sel_data;
  assign bus.pmem_rdata = rdata;
  assign bus.pmem_resp  = state == RESP;
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [11:0] tag;
  logic error;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag   <= '0;
      error <= 1'b0;
    end else begin
      if (accept) tag <= bus.pmem_address[15:4];
      if ((accept && bus.pmem_read && bus.pmem_write) ||
          (state == BUSY && ((is_wr ? !bus.pmem_write : !bus.pmem_read) || bus.pmem_address[15:4] != tag)))
        error <= 1'b1;
    end
  end
  assign bus.pmem_error = error;
`else
  assign bus.pmem_error = 1'b0;
`endif
endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: vector table, random ops against a line-array model, and timing corner cases.
module tb_pmem_line_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pmem_line_responder_if b4();
  pmem_line_responder_if b1();
  pmem_line_responder #(.lines(32), .log_line(5), .latency(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  pmem_line_responder #(.lines(32), .log_line(5), .latency(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic chk_en = 1'b1;
`else
  localparam logic chk_en = 1'b0;
`endif
  typedef struct {
    logic         w;
    logic [15:0]  a;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [8];
  int pass = 0;
  int total = 0;
  logic [127:0] model [32];
  bit valid [32];
  localparam logic [127:0] P = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic op4(input logic w, input logic r, input logic [15:0] a, input logic [127:0] d,
                     output int n, output logic [127:0] q);
    b4.pmem_write = w; b4.pmem_read = r; b4.pmem_address = a; b4.pmem_wdata = d;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (b4.pmem_resp) n = i;
    end
    b4.pmem_write = 1'b0; b4.pmem_read = 1'b0;
    q = b4.pmem_rdata;
    @(negedge clk);
    chk("resp_single_cycle", b4.pmem_resp, 0);
  endtask

  task automatic mwrite(input logic [15:0] a, input logic [127:0] d);
    int n; logic [127:0] q;
    op4(1'b1, 1'b0, a, d, n, q);
    chk("wr_latency", n, 4);
    model[a[8:4]] = d;
    valid[a[8:4]] = 1'b1;
  endtask

  task automatic mread(input logic [15:0] a, input string name);
    int n; logic [127:0] q;
    op4(1'b0, 1'b1, a, '0, n, q);
    chk("rd_latency", n, 4);
    if (valid[a[8:4]]) chk(name, q, model[a[8:4]]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, k, holds, cnt;
    int t [3];
    logic [127:0] q, held, x;
    logic [15:0] a;
    b4.pmem_read = 0; b4.pmem_write = 0; b4.pmem_address = 0; b4.pmem_wdata = 0;
    b1.pmem_read = 0; b1.pmem_write = 0; b1.pmem_address = 0; b1.pmem_wdata = 0;
    foreach (valid[i]) valid[i] = 1'b0;
    tbl[0] = '{1'b1, 16'h0040, P, '0};
    tbl[1] = '{1'b0, 16'h004C, '0, P};
    tbl[2] = '{1'b1, 16'h0010, {4{32'h1111_1111}}, '0};
    tbl[3] = '{1'b0, 16'h0210, '0, {4{32'h1111_1111}}};
    tbl[4] = '{1'b1, 16'h01F0, {4{32'hDEAD_BEEF}}, '0};
    tbl[5] = '{1'b0, 16'h03F4, '0, {4{32'hDEAD_BEEF}}};
    tbl[6] = '{1'b1, 16'h0010, {4{32'h5A5A_0F0F}}, '0};
    tbl[7] = '{1'b0, 16'h0018, '0, {4{32'h5A5A_0F0F}}};

    repeat (2) @(negedge clk);
    chk("reset_resp", b4.pmem_resp, 0);
    chk("reset_rdata", b4.pmem_rdata, 0);
    chk("reset_error", b4.pmem_error, 0);
    chk("reset_resp_l1", b1.pmem_resp, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      op4(tbl[i].w, !tbl[i].w, tbl[i].a, tbl[i].d, n, q);
      chk(tbl[i].w ? "tbl_wr_latency" : "tbl_rd_latency", n, 4);
      if (!tbl[i].w) chk("tbl_rdata", q, tbl[i].exp);
      if (tbl[i].w) begin model[tbl[i].a[8:4]] = tbl[i].d; valid[tbl[i].a[8:4]] = 1'b1; end
    end
    chk("no_error_clean", b4.pmem_error, 0);

    mwrite(16'h0010, {4{32'hAAAA_0001}});
    mwrite(16'h0020, {4{32'hBBBB_0002}});
    mwrite(16'h0030, {4{32'hCCCC_0003}});
    b4.pmem_read = 1'b1; b4.pmem_address = 16'h0010;
    t = '{0, 0, 0}; k = 0; holds = 0; held = '0;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge clk);
      if (b4.pmem_resp) begin
        t[k] = c;
        chk("b2b_data", b4.pmem_rdata, model[k + 1]);
        held = b4.pmem_rdata;
        k++;
        b4.pmem_address = 16'((k + 1) * 16);
      end else if (k > 0 && b4.pmem_rdata !== held) holds++;
    end
    b4.pmem_read = 1'b0;
    @(negedge clk);
    chk("b2b_count", k, 3);
    chk("b2b_gap1", t[1] - t[0], 5);
    chk("b2b_gap2", t[2] - t[1], 5);
    chk("b2b_hold", holds, 0);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mwrite(a, {$urandom, $urandom, $urandom, $urandom});
      else mread(a, "rand_rdata");
    end

    mwrite(16'h0050, '0);
    b4.pmem_write = 1'b1; b4.pmem_address = 16'h0050; b4.pmem_wdata = '1;
    repeat (2) @(negedge clk);
    reset = 1'b1; b4.pmem_write = 1'b0;
    #1;
    chk("abort_resp", b4.pmem_resp, 0);
    chk("abort_rdata", b4.pmem_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (b4.pmem_resp) cnt++;
    end
    chk("abort_no_resp", cnt, 0);
    mread(16'h0050, "abort_read");

    x = {$urandom, $urandom, $urandom, $urandom};
    b1.pmem_write = 1'b1; b1.pmem_read = 1'b1; b1.pmem_address = 16'h0070; b1.pmem_wdata = x;
    @(negedge clk);
    chk("l1_resp", b1.pmem_resp, 1);
    b1.pmem_write = 1'b0; b1.pmem_read = 1'b0;
    @(negedge clk);
    chk("l1_resp_off", b1.pmem_resp, 0);
    chk("l1_error", b1.pmem_error, chk_en);
    b1.pmem_read = 1'b1;
    @(negedge clk);
    chk("l1_rd_resp", b1.pmem_resp, 1);
    chk("l1_rdata", b1.pmem_rdata, x);
    b1.pmem_read = 1'b0;
    @(negedge clk);
    chk("l1_rd_resp_off", b1.pmem_resp, 0);

    x = {4{32'hF00D_0100}};
    b4.pmem_write = 1'b1; b4.pmem_address = 16'h0100; b4.pmem_wdata = x;
    @(negedge clk);
    b4.pmem_address = 16'h0200;
    n = 0;
    for (int i = 2; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (b4.pmem_resp) n = i;
    end
    b4.pmem_write = 1'b0;
    chk("mid_change_latency", n, 4);
    chk("mid_change_error", b4.pmem_error, chk_en);
    @(negedge clk);
    model[16] = x; valid[16] = 1'b1;
    mread(16'h0100, "mid_change_line");
    chk("error_sticky", b4.pmem_error, chk_en);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("error_cleared", b4.pmem_error, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory responder for the 128-bit line interface that the instruction and data caches drive as initiators. Accepts one line read or line write at a time, holds it for a fixed, parameterised access latency, then completes it with a single-cycle `pmem_resp` pulse. It backs the cache hierarchy in simulation and in the standalone memory subsystem, and it makes the cache miss/writeback timing deterministic.

## Interface
- `lines`, 32: number of 128-bit lines stored.
- `log_line`, 5: log2(`lines`); line index = `pmem_address[log_line+3:4]`.
- `latency`, 4: cycles from request acceptance to `pmem_resp`; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pmem_read`  in  1  line read request; held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  line write request; held by the initiator until `pmem_resp`.
- `pmem_address`  in  16  byte address; bits [3:0] ignored; bits above the index alias.
- `pmem_wdata`  in  128  write line (`lc3b_block`).
- `pmem_rdata`  out  128  read line; valid while `pmem_resp`=1 and held until the next read completes.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_error`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if `pmem_write` or `pmem_read` is sampled high at an edge, latch the command, index and `pmem_wdata`, load the counter with `latency`-1, and go to BUSY. If `latency`=1, go straight to RESP instead.
- Both `pmem_read` and `pmem_write` high in IDLE: the write wins and the read is ignored.
- BUSY: decrement the counter each edge. When the counter reaches 0, go to RESP on that edge.
- On the edge entering RESP:
  - Write: array[index] <= latched wdata.
  - Read: `pmem_rdata` <= array[index].
- RESP: `pmem_resp`=1 for exactly one cycle, then return to IDLE unconditionally.
- Back-to-back: a request still high in the IDLE cycle after RESP is a new transaction.
- Requests are sampled only in IDLE. Changes to the inputs during BUSY or RESP do not affect the latched transaction.
- Read-after-write to the same line returns the newly written data.
- The array is not reset. Contents are undefined until written.

## Timing
- Request accepted at edge k. `pmem_resp` is high in the cycle after edge k+`latency`-1, i.e. `latency` cycles after acceptance.
- Minimum spacing between accepted requests: `latency`+1 cycles.
- Reset values: state IDLE, `pmem_resp`=0, `pmem_rdata`=0, counter=0, `pmem_error`=0.
- Reset asserted mid-transaction aborts immediately. A write not yet committed is dropped and the array is unchanged; no `pmem_resp` is produced.
- Counter is 8 bits wide. Its maximum value is `latency`-1, so it never wraps.

## Configuration
- `PMEM_PROTOCOL_CHECK_EN` defined: protocol checker compiled in. `pmem_error` is set and held until reset when either of these occurs:
  - `pmem_read` and `pmem_write` are both high at acceptance;
  - during BUSY, the asserted command drops, or `pmem_address[15:4]` differs from the latched value.
- Data-path behaviour is identical with or without the checker.
- Not defined: checker absent and `pmem_error` tied to 0.

## Test plan
- Reset, then write 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 to 16'h0040 with `latency`=4:
  - `pmem_resp` high exactly 4 cycles after acceptance, for one cycle.
  - A read of 16'h004C (same line) then returns that value 4 cycles after its acceptance.
- Back-to-back: reads held continuously across lines 1, 2, 3 give `pmem_resp` pulses 5 cycles apart. `pmem_rdata` holds each line's value until the next read's RESP.
- Aliasing: write line at 16'h0010, then read 16'h0210 (`lines`=32) -> the same data is returned.
- `latency`=1: accept at edge k, `pmem_resp`=1 in the next cycle, then idle. Read and write both high at acceptance -> the write is committed and `pmem_error`=1 only with `PMEM_PROTOCOL_CHECK_EN` (0 without).
- Reset pulse 2 cycles after accepting a write of 128'hFF..FF to a line previously holding 128'h0 -> no `pmem_resp`; a later read returns 128'h0.
- With `PMEM_PROTOCOL_CHECK_EN`, change `pmem_address` from 16'h0100 to 16'h0200 mid-BUSY:
  - `pmem_error` rises and stays 1 until reset;
  - the response completes for line 16'h0100.
